// File: rtl/fight_pkg.sv
// fight_pkg: shared state encodings, skill codes and per-skill movement/damage tables.
package fight_pkg;

  localparam int unsigned SKILL_W = 3;
  localparam int unsigned DELTA_W = 4;
  localparam int unsigned DMG_W   = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WINDUP  = 3'd1,
    ST_ACTIVE  = 3'd2,
    ST_RECOVER = 3'd3,
    ST_KO      = 3'd4
  } state_t;

  localparam logic [SKILL_W-1:0] SK_TELEPORT_M = 3'd0;
  localparam logic [SKILL_W-1:0] SK_TELEPORT_P = 3'd7;

  localparam logic signed [DELTA_W-1:0] SKILL_DELTA [0:7] =
    '{4'sd0, 4'sd2, 4'sd1, 4'sd0, -4'sd2, 4'sd0, 4'sd1, 4'sd0};
  localparam logic [DMG_W-1:0] SKILL_DMG [0:7] =
    '{3'd0, 3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd4};

endpackage

// File: rtl/action_timer.sv
// action_timer: loadable down-counter; done_c is high while the count sits at zero.
module action_timer #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done_c
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset)               count <= '0;
    else if (load)           count <= load_val;
    else if (count != '0)    count <= count - CNT_W'(1);
  end

  assign done_c = (count == '0);

endmodule

// File: rtl/skill_executor.sv
// skill_executor: runs decoded skills as windup/active/recover actions, updating position, HP and KO.
// Define SKILL_QUEUE_EN to hold one skill that arrives mid-action and chain it after recovery.
module skill_executor
  import fight_pkg::*;
#(
  parameter int unsigned POS_W       = 4,
  parameter int unsigned START_POS   = 2,
  parameter int unsigned HP_W        = 5,
  parameter int unsigned HP_MAX      = 20,
  parameter int unsigned RANGE       = 1,
  parameter int unsigned WINDUP_CYC  = 2,
  parameter int unsigned RECOVER_CYC = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               skill_valid,
  input  logic [2:0]         skill,
  input  logic               heavy_pounch,
  input  logic               teleport,
  input  logic [POS_W-1:0]   opp_pos,
  output logic               busy,
  output logic [POS_W-1:0]   pos,
  output logic [HP_W-1:0]    opp_hp,
  output logic               hit,
  output logic               ko,
  output logic               dropped,
  output logic [2:0]         fsm_state
);

  localparam int unsigned SW      = POS_W + 2;
  localparam int unsigned MAX_CYC = (WINDUP_CYC > RECOVER_CYC) ? WINDUP_CYC : RECOVER_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;
  localparam logic [CNT_W-1:0] WINDUP_LD  = CNT_W'(WINDUP_CYC - 1);
  localparam logic [CNT_W-1:0] RECOVER_LD = CNT_W'(RECOVER_CYC - 1);

  state_t               state, state_nx;
  logic [SKILL_W-1:0]   sk_code, code_nx;
  logic                 sk_heavy, heavy_nx, sk_tele, tele_nx;
  logic [POS_W-1:0]     pos_nx;
  logic [HP_W-1:0]      hp_nx;
  logic                 hit_nx, ko_nx, dropped_nx;
  logic                 tmr_load, tmr_done_c;
  logic [CNT_W-1:0]     tmr_val;

`ifdef SKILL_QUEUE_EN
  logic                 pend_valid, pend_valid_nx;
  logic [SKILL_W-1:0]   pend_code, pend_code_nx;
  logic                 pend_heavy, pend_heavy_nx, pend_tele, pend_tele_nx;
`endif

  action_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done_c   (tmr_done_c)
  );

  // Outcome of the latched skill if it resolves this cycle.
  logic [POS_W-1:0]          lim, act_pos;
  logic signed [DELTA_W-1:0] delta;
  logic signed [SW-1:0]      delta_ext, pos_sum;
  logic                      act_conn;
  logic [HP_W-1:0]           act_dmg, act_hp;

  always_comb begin
    lim       = (opp_pos == '0) ? '0 : opp_pos - POS_W'(1);
    delta     = SKILL_DELTA[sk_code];
    delta_ext = SW'(delta);
    pos_sum   = $signed({2'b00, pos}) + delta_ext;
    if (sk_tele)                                act_pos = lim;
    else if (pos_sum[SW-1])                     act_pos = '0;
    else if (pos_sum > $signed({2'b00, lim}))   act_pos = lim;
    else                                        act_pos = pos_sum[POS_W-1:0];
    act_conn = ({2'b00, act_pos} + SW'(RANGE)) >= {2'b00, opp_pos};
    act_dmg  = act_conn ? (HP_W'(SKILL_DMG[sk_code]) << sk_heavy) : '0;
    act_hp   = (opp_hp > act_dmg) ? opp_hp - act_dmg : '0;
  end

  always_comb begin
    state_nx   = state;
    code_nx    = sk_code;
    heavy_nx   = sk_heavy;
    tele_nx    = sk_tele;
    pos_nx     = pos;
    hp_nx      = opp_hp;
    hit_nx     = 1'b0;
    ko_nx      = ko;
    dropped_nx = 1'b0;
    tmr_load   = 1'b0;
    tmr_val    = '0;
`ifdef SKILL_QUEUE_EN
    pend_valid_nx = pend_valid;
    pend_code_nx  = pend_code;
    pend_heavy_nx = pend_heavy;
    pend_tele_nx  = pend_tele;
`endif

    if (skill_valid && state != ST_IDLE && state != ST_KO) begin
`ifdef SKILL_QUEUE_EN
      if (!pend_valid) begin
        pend_valid_nx = 1'b1;
        pend_code_nx  = skill;
        pend_heavy_nx = heavy_pounch;
        pend_tele_nx  = teleport;
      end else begin
        dropped_nx = 1'b1;
      end
`else
      dropped_nx = 1'b1;
`endif
    end

    case (state)
      ST_IDLE: if (skill_valid) begin
        code_nx  = skill;
        heavy_nx = heavy_pounch;
        tele_nx  = teleport;
        state_nx = ST_WINDUP;
        tmr_load = 1'b1;
        tmr_val  = WINDUP_LD;
      end
      ST_WINDUP: if (tmr_done_c) state_nx = ST_ACTIVE;
      ST_ACTIVE: begin
        pos_nx = act_pos;
        hp_nx  = act_hp;
        hit_nx = (act_dmg != '0);
        if (act_hp == '0) begin
          state_nx = ST_KO;
          ko_nx    = 1'b1;
`ifdef SKILL_QUEUE_EN
          pend_valid_nx = 1'b0;
`endif
        end else begin
          state_nx = ST_RECOVER;
          tmr_load = 1'b1;
          tmr_val  = RECOVER_LD;
        end
      end
      ST_RECOVER: if (tmr_done_c) begin
        state_nx = ST_IDLE;
`ifdef SKILL_QUEUE_EN
        // Chain straight into the held skill, skipping IDLE.
        if (pend_valid_nx) begin
          code_nx       = pend_code_nx;
          heavy_nx      = pend_heavy_nx;
          tele_nx       = pend_tele_nx;
          pend_valid_nx = 1'b0;
          state_nx      = ST_WINDUP;
          tmr_load      = 1'b1;
          tmr_val       = WINDUP_LD;
        end
`endif
      end
      ST_KO:   state_nx = ST_KO;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      sk_code  <= '0;
      sk_heavy <= 1'b0;
      sk_tele  <= 1'b0;
      pos      <= POS_W'(START_POS);
      opp_hp   <= HP_W'(HP_MAX);
      hit      <= 1'b0;
      ko       <= 1'b0;
      dropped  <= 1'b0;
      busy     <= 1'b0;
`ifdef SKILL_QUEUE_EN
      pend_valid <= 1'b0;
      pend_code  <= '0;
      pend_heavy <= 1'b0;
      pend_tele  <= 1'b0;
`endif
    end else begin
      state    <= state_nx;
      sk_code  <= code_nx;
      sk_heavy <= heavy_nx;
      sk_tele  <= tele_nx;
      pos      <= pos_nx;
      opp_hp   <= hp_nx;
      hit      <= hit_nx;
      ko       <= ko_nx;
      dropped  <= dropped_nx;
      busy     <= (state_nx != ST_IDLE);
`ifdef SKILL_QUEUE_EN
      pend_valid <= pend_valid_nx;
      pend_code  <= pend_code_nx;
      pend_heavy <= pend_heavy_nx;
      pend_tele  <= pend_tele_nx;
`endif
    end
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_skill_executor.sv
// tb_skill_executor: directed + randomized stimulus checked every cycle against a timeline model.
module tb_skill_executor;

  localparam int W = 2;
  localparam int R = 3;
  localparam int RNG = 1;
`ifdef SKILL_QUEUE_EN
  localparam bit QEN = 1'b1;
`else
  localparam bit QEN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       skill_valid = 1'b0;
  logic [2:0] skill = 3'd0;
  logic       heavy_pounch = 1'b0;
  logic       teleport = 1'b0;
  logic [3:0] opp_pos = 4'd10;
  logic       busy, hit, ko, dropped;
  logic [3:0] pos;
  logic [4:0] opp_hp;
  logic [2:0] fsm_state;

  skill_executor dut (
    .clk          (clk),
    .reset        (reset),
    .skill_valid  (skill_valid),
    .skill        (skill),
    .heavy_pounch (heavy_pounch),
    .teleport     (teleport),
    .opp_pos      (opp_pos),
    .busy         (busy),
    .pos          (pos),
    .opp_hp       (opp_hp),
    .hit          (hit),
    .ko           (ko),
    .dropped      (dropped),
    .fsm_state    (fsm_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: m_el counts cycles since acceptance (0 = idle); phase follows from it.
  int dtab [0:7] = '{0, 2, 1, 0, -2, 0, 1, 0};
  int btab [0:7] = '{0, 0, 1, 2, 0, 1, 2, 4};
  int m_pos, m_hp, m_el, m_sk, m_ps;
  bit m_ko, m_hit, m_drop, m_hv, m_tp, m_pv, m_phv, m_ptp;

  always @(posedge clk) begin
    if (reset) begin
      m_pos = 2; m_hp = 20; m_ko = 0; m_hit = 0; m_drop = 0; m_el = 0; m_pv = 0;
    end else begin
      m_hit = 0; m_drop = 0;
      if (!m_ko) begin
        if (m_el == 0) begin
          if (skill_valid) begin
            m_sk = int'(skill); m_hv = heavy_pounch; m_tp = teleport; m_el = 1;
          end
        end else begin
          if (skill_valid) begin
            if (QEN && !m_pv) begin
              m_pv = 1; m_ps = int'(skill); m_phv = heavy_pounch; m_ptp = teleport;
            end else m_drop = 1;
          end
          if (m_el == W + 1) begin
            int lim, np, dmg;
            lim = (opp_pos == 0) ? 0 : int'(opp_pos) - 1;
            np = m_tp ? lim : m_pos + dtab[m_sk];
            if (np < 0) np = 0;
            if (np > lim) np = lim;
            dmg = (np + RNG >= int'(opp_pos)) ? btab[m_sk] * (m_hv ? 2 : 1) : 0;
            m_pos = np;
            m_hp = (m_hp > dmg) ? m_hp - dmg : 0;
            m_hit = (dmg > 0);
            if (m_hp == 0) begin m_ko = 1; m_pv = 0; m_el = 0; end
            else m_el++;
          end else if (m_el == W + 1 + R) begin
            if (m_pv) begin
              m_sk = m_ps; m_hv = m_phv; m_tp = m_ptp; m_pv = 0; m_el = 1;
            end else m_el = 0;
          end else m_el++;
        end
      end
    end
  end

  function automatic int exp_state();
    if (m_ko) return 4;
    if (m_el == 0) return 0;
    if (m_el <= W) return 1;
    if (m_el == W + 1) return 2;
    return 3;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", int'(busy), int'(m_ko || m_el != 0));
      chk("pos", int'(pos), m_pos);
      chk("opp_hp", int'(opp_hp), m_hp);
      chk("hit", int'(hit), int'(m_hit));
      chk("ko", int'(ko), int'(m_ko));
      chk("dropped", int'(dropped), int'(m_drop));
      chk("fsm_state", int'(fsm_state), exp_state());
    end
  end

  task automatic do_reset();
    @(negedge clk); reset = 1'b1; skill_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic do_skill(input int sk, input bit hv, input bit tp,
                          output int busy_n, output int hit_n, output int pos3);
    @(negedge clk);
    skill_valid = 1'b1; skill = 3'(sk); heavy_pounch = hv; teleport = tp;
    @(negedge clk);
    skill_valid = 1'b0;
    busy_n = 0; hit_n = 0; pos3 = -1;
    for (int i = 0; i < 40; i++) begin
      if (i == 3) pos3 = int'(pos);
      if (hit) hit_n++;
      if (!busy || fsm_state == 3'd4) break;
      busy_n++;
      @(negedge clk);
    end
    if (busy && fsm_state != 3'd4) chk("action_timeout", 1, 0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    if (busy) chk("idle_timeout", 1, 0);
  endtask

  initial begin
    int bn, hn, p3, nd;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_pos", int'(pos), 2);
    chk("rst_hp", int'(opp_hp), 20);
    chk("rst_hit", int'(hit), 0);
    chk("rst_ko", int'(ko), 0);
    chk("rst_dropped", int'(dropped), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_state", int'(fsm_state), 0);
    reset = 1'b0;

    do_skill(1, 0, 0, bn, hn, p3);
    chk("walk_pos_at3", p3, 4);
    chk("walk_busy_cycles", bn, 6);
    chk("walk_hit", hn, 0);
    chk("walk_hp", int'(opp_hp), 20);

    do_skill(0, 0, 1, bn, hn, p3);
    chk("tele_pos", int'(pos), 9);
    do_skill(3, 0, 0, bn, hn, p3);
    chk("jab_hp", int'(opp_hp), 18);
    chk("jab_hit_pulses", hn, 1);
    do_skill(3, 1, 0, bn, hn, p3);
    chk("heavy_hp", int'(opp_hp), 14);

    // Second skill lands two cycles into the first action.
    @(negedge clk); skill_valid = 1'b1; skill = 3'd5; heavy_pounch = 1'b0; teleport = 1'b0;
    @(negedge clk); skill_valid = 1'b0;
    @(negedge clk); skill_valid = 1'b1; skill = 3'd2;
    @(negedge clk); skill_valid = 1'b0;
    chk("busy_drop_pulse", int'(dropped), QEN ? 0 : 1);
    @(negedge clk);
    chk("busy_drop_once", int'(dropped), 0);
    repeat (3) @(negedge clk);
    chk("after_recover_state", int'(fsm_state), QEN ? 1 : 0);
    wait_idle();
    chk("busy_drop_hp", int'(opp_hp), QEN ? 12 : 13);

    do_reset();
    do_skill(7, 1, 1, bn, hn, p3);
    chk("ko_hp1", int'(opp_hp), 12);
    do_skill(7, 1, 1, bn, hn, p3);
    chk("ko_hp2", int'(opp_hp), 4);
    do_skill(7, 1, 1, bn, hn, p3);
    chk("ko_hp3", int'(opp_hp), 0);
    chk("ko_flag", int'(ko), 1);
    chk("ko_state", int'(fsm_state), 4);
    nd = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); skill_valid = (i < 3); skill = 3'd7;
      if (dropped) nd++;
    end
    skill_valid = 1'b0;
    chk("ko_no_drop", nd, 0);
    chk("ko_stays", int'(fsm_state), 4);
    do_reset();
    chk("ko_reset_hp", int'(opp_hp), 20);
    chk("ko_reset_ko", int'(ko), 0);

    do_skill(0, 0, 1, bn, hn, p3);
    do_skill(1, 0, 0, bn, hn, p3);
    chk("clamp_hi", int'(pos), 9);
    opp_pos = 4'd0;
    do_skill(1, 0, 0, bn, hn, p3);
    chk("clamp_opp0", int'(pos), 0);
    opp_pos = 4'd10;
    do_skill(2, 0, 0, bn, hn, p3);
    chk("step_to_1", int'(pos), 1);
    do_skill(4, 0, 0, bn, hn, p3);
    chk("clamp_lo", int'(pos), 0);

    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 79) == 0);
      skill_valid = ($urandom_range(0, 2) == 0);
      skill = 3'($urandom_range(0, 7));
      heavy_pounch = 1'($urandom_range(0, 1));
      teleport = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) opp_pos = 4'($urandom_range(0, 15));
    end
    @(negedge clk); skill_valid = 1'b0; reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/skill_executor.md
Name: skill_executor

Overview:
- Downstream consumer of the combo decoder (`operation`).
- Accepts a decoded skill code plus its heavy_pounch/teleport flags and runs a timed action: windup, active hit, recovery.
- Updates the player position, opponent HP and KO status that feed the display/score stage.
- Drops or queues skills that arrive while an action is in progress.

Parameters:
- POS_W, 4, width of position values.
- START_POS, 2, player position after reset.
- HP_W, 5, width of opponent HP.
- HP_MAX, 20, opponent HP after reset.
- RANGE, 1, maximum (opp_pos - pos) at which a hit connects.
- WINDUP_CYC, 2, cycles spent in WINDUP (≥1).
- RECOVER_CYC, 3, cycles spent in RECOVER (≥1).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high; all state returns to reset values on the next edge
- skill_valid  in  1  one-cycle strobe: skill/heavy_pounch/teleport are valid
- skill  in  3  decoded combo code 0..7
- heavy_pounch  in  1  doubles damage of this skill
- teleport  in  1  position jumps to opp_pos-1 instead of applying delta
- opp_pos  in  POS_W  opponent position, sampled in ACTIVE
- busy  out  1  state != IDLE
- pos  out  POS_W  player position, reset START_POS
- opp_hp  out  HP_W  opponent HP, reset HP_MAX
- hit  out  1  one-cycle pulse when nonzero damage is applied, reset 0
- ko  out  1  sticky once opp_hp reaches 0, reset 0
- dropped  out  1  one-cycle pulse when a skill_valid is discarded, reset 0
- fsm_state  out  3  IDLE=0, WINDUP=1, ACTIVE=2, RECOVER=3, KO=4; reset 0

Behaviour:
- Skill table (delta, base damage):
  - 0: (0, 0)
  - 1: (+2, 0)
  - 2: (+1, 1)
  - 3: (0, 2)
  - 4: (-2, 0)
  - 5: (0, 1)
  - 6: (+1, 2)
  - 7: (0, 4)
- FSM:
  - IDLE: skill_valid latches skill/heavy/teleport and moves to WINDUP. Edge E0 = acceptance.
  - WINDUP: counts WINDUP_CYC cycles, then ACTIVE.
  - ACTIVE: one cycle. On the edge leaving ACTIVE (E_{W+1}):
    - pos, opp_hp and hit are updated.
    - Next state is KO if the new opp_hp == 0, otherwise RECOVER.
  - RECOVER: counts RECOVER_CYC cycles, then IDLE.
  - KO: terminal until reset. All skill_valid ignored; dropped does not pulse.
- Latency:
  - New pos/opp_hp/hit visible WINDUP_CYC+1 cycles after acceptance (3 with defaults).
  - busy high for WINDUP_CYC+1+RECOVER_CYC cycles (6 with defaults).
- Position:
  - lim = (opp_pos==0) ? 0 : opp_pos-1.
  - teleport=1: pos := lim.
  - Otherwise pos := clamp(pos + signed delta, 0, lim).
  - Arithmetic is signed, POS_W+2 bits, before clamping.
  - If pos > lim already, it is clamped down to lim.
- Damage:
  - dmg = base << heavy_pounch.
  - Applies only if new pos + RANGE ≥ opp_pos.
  - opp_hp := max(opp_hp - dmg, 0), saturating and never wrapping.
  - hit = 1 iff the applied dmg > 0.
- skill_valid while busy and not KO: discarded, dropped pulses the next cycle. This includes the last RECOVER cycle.
- Reset has priority over every event, including mid-action; any latched skill is lost.

Optional Feature:
- Macro: SKILL_QUEUE_EN.
- Defined: one-entry pending register.
  - skill_valid while busy (not KO) with the register empty is stored, no dropped pulse.
  - With the register full: dropped pulses and the register is unchanged.
  - At RECOVER end with a pending entry: go directly to WINDUP (no IDLE cycle) and clear the register.
  - Entering KO or reset clears the register.
- Undefined: no pending register; every busy-time skill_valid is dropped.

Decomposition:
- Shared package fight_pkg:
  - state encodings;
  - SKILL_DELTA[0:7] and SKILL_DMG[0:7] constant tables;
  - skill code constants (SK_TELEPORT_M=0, SK_TELEPORT_P=7).
- Sub-module action_timer: loadable down-counter with done flag, used for WINDUP and RECOVER.
- Clamp and damage logic stay inline.

Test Plan (defaults; opp_pos=10 unless stated):
- Reset with reset=1 for 2 edges → pos=2, opp_hp=20, hit=ko=dropped=busy=0, fsm_state=0.
- skill=1, no flags → pos=4 three cycles after acceptance; hit=0; opp_hp=20; busy high exactly 6 cycles.
- skill=0 teleport=1 → pos=9. Then skill=3 → opp_hp=18, hit pulses 1 cycle. Then skill=3 heavy → opp_hp=14.
- Accept skill=5, then pulse skill_valid 2 cycles later → dropped=1 for one cycle, state/pos/hp unaffected. With SKILL_QUEUE_EN, the second skill executes immediately after RECOVER with no IDLE cycle.
- skill=7 teleport=1 heavy=1, three times → opp_hp 12, 4, 0; ko=1, fsm_state=4. Further skill_valid ignored with no dropped pulse. reset → opp_hp=20, ko=0.
- Clamps:
  - pos=9 with skill=1 → pos stays 9.
  - From pos=1, skill=4 → pos=0.
  - opp_pos=0 with skill=1 → pos=0.
